// File: rtl/dtree_pkg.sv
// dtree_pkg: widths and helpers shared by the decision-tree controller and node evaluator
package dtree_pkg;

   function automatic int max_int(input int a, input int b);
      return a > b ? a : b;
   endfunction

   localparam int FEATURES          = 3;
   localparam int COEFF_BIT_DEPTH   = 4;
   localparam int BIAS_BIT_DEPTH    = 10;
   localparam int FEATURE_BIT_DEPTH = 8;
   localparam int ACC_WIDTH         = max_int(BIAS_BIT_DEPTH, FEATURE_BIT_DEPTH + COEFF_BIT_DEPTH)
                                      + $clog2(FEATURES + 1) + 1;

   // Feature 0 sits in the most-significant slice of a packed vector
   function automatic int feat_lsb(input int idx, input int n, input int w);
      return (n - 1 - idx) * w;
   endfunction

endpackage

// File: rtl/coeff_mult.sv
// coeff_mult: combinational signed feature x coefficient with zero/one bypass
module coeff_mult
#(
   parameter int FW = dtree_pkg::FEATURE_BIT_DEPTH,
   parameter int CW = dtree_pkg::COEFF_BIT_DEPTH
)(
   input  logic signed [FW-1:0]    feature_i,
   input  logic signed [CW-1:0]    coeff_i,
   input  logic                    mult_i,
   input  logic                    is_one_i,
   output logic signed [FW+CW-1:0] term_o
);

   // is_one wins over mult; neither selected yields a zero term
   always_comb begin
      term_o = '0;
      if (is_one_i)
         term_o = feature_i;
      else if (mult_i)
         term_o = feature_i * coeff_i;
   end

endmodule

// File: rtl/node_evaluator.sv
// node_evaluator: buffers feature vectors and accumulates bias + sum(coeff*feature) per node.
// Define NODE_EVAL_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module node_evaluator
#(
   parameter int FEATURES          = dtree_pkg::FEATURES,
   parameter int COEFF_BIT_DEPTH   = dtree_pkg::COEFF_BIT_DEPTH,
   parameter int BIAS_BIT_DEPTH    = dtree_pkg::BIAS_BIT_DEPTH,
   parameter int FEATURE_BIT_DEPTH = dtree_pkg::FEATURE_BIT_DEPTH,
   parameter int ACC_WIDTH         = dtree_pkg::max_int(BIAS_BIT_DEPTH, FEATURE_BIT_DEPTH + COEFF_BIT_DEPTH)
                                     + $clog2(FEATURES + 1) + 1
)(
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [FEATURES*FEATURE_BIT_DEPTH-1:0] in_features,
   input  logic                                  load_bias,
   input  logic                                  add,
   input  logic                                  mult,
   input  logic                                  is_one,
   input  logic [COEFF_BIT_DEPTH-1:0]            coeff,
   input  logic [BIAS_BIT_DEPTH-1:0]             bias,
   input  logic                                  tree_done,
   output logic                                  child_direction,
   output logic                                  next,
   output logic                                  sample_active,
   output logic [ACC_WIDTH-1:0]                  acc,
   output logic                                  overflow,
   output logic                                  underrun
);

   import dtree_pkg::*;

   localparam int KW = FEATURES > 1 ? $clog2(FEATURES) : 1;
   localparam int VW = FEATURES * FEATURE_BIT_DEPTH;
   localparam int PW = FEATURE_BIT_DEPTH + COEFF_BIT_DEPTH;
   localparam int SW = max_int(max_int(ACC_WIDTH, BIAS_BIT_DEPTH), PW) + 2;

   logic [VW-1:0]                  active_q, active_d, pending_q, pending_d;
   logic                           act_v_q, act_v_d, pend_v_q, pend_v_d;
   logic                           next_q, next_d, rdy_q;
   logic                           ovf_q, ovf_d, und_q, und_d;
   logic [KW-1:0]                  k_q, k_d, idx;
   logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
   logic signed [FEATURE_BIT_DEPTH-1:0] x;
   logic signed [PW-1:0]           term;
   logic signed [SW-1:0]           base, sum;
   logic                           accept, promote, act_v_ret, sum_ovf;

   coeff_mult #(.FW(FEATURE_BIT_DEPTH), .CW(COEFF_BIT_DEPTH)) u_mult (
      .feature_i (x),
      .coeff_i   ($signed(coeff)),
      .mult_i    (mult),
      .is_one_i  (is_one),
      .term_o    (term)
   );

   // Term selection and one add stage; the sum is kept wide so overflow is exact
   always_comb begin
      idx     = load_bias ? '0 : k_q;
      x       = act_v_q ? active_q[feat_lsb(int'(idx), FEATURES, FEATURE_BIT_DEPTH) +: FEATURE_BIT_DEPTH] : '0;
      base    = load_bias ? SW'($signed(bias)) : SW'(acc_q);
      sum     = base + SW'(term);
      sum_ovf = sum != SW'($signed(sum[ACC_WIDTH-1:0]));
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      und_d   = und_q;
      k_d     = k_q;
      if (add) begin
`ifdef NODE_EVAL_SAT_EN
         acc_d = !sum_ovf ? sum[ACC_WIDTH-1:0] :
                 sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
         acc_d = sum[ACC_WIDTH-1:0];
`endif
         ovf_d = ovf_q | sum_ovf;
         und_d = und_q | ~act_v_q;
         k_d   = (idx == KW'(FEATURES - 1)) ? '0 : idx + 1'b1;
      end
   end

   // Two-slot buffer: retire/promote first, then an accepted word fills the first free slot
   always_comb begin
      promote   = tree_done & pend_v_q;
      act_v_ret = tree_done ? pend_v_q : act_v_q;
      accept    = in_valid & rdy_q;
      active_d  = promote ? pending_q : active_q;
      act_v_d   = act_v_ret;
      pending_d = pending_q;
      pend_v_d  = pend_v_q & ~tree_done;
      next_d    = promote;
      if (accept) begin
         if (!act_v_ret) begin
            active_d = in_features;
            act_v_d  = 1'b1;
            next_d   = 1'b1;
         end else begin
            pending_d = in_features;
            pend_v_d  = 1'b1;
         end
      end
   end

   // State registers; reset discards buffered samples and the node in progress
   always_ff @(posedge clk) begin
      if (!reset) begin
         active_q  <= '0;
         pending_q <= '0;
         act_v_q   <= 1'b0;
         pend_v_q  <= 1'b0;
         next_q    <= 1'b0;
         rdy_q     <= 1'b0;
         ovf_q     <= 1'b0;
         und_q     <= 1'b0;
         k_q       <= '0;
         acc_q     <= '0;
      end else begin
         active_q  <= active_d;
         pending_q <= pending_d;
         act_v_q   <= act_v_d;
         pend_v_q  <= pend_v_d;
         next_q    <= next_d;
         rdy_q     <= ~(act_v_d & pend_v_d);
         ovf_q     <= ovf_d;
         und_q     <= und_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
      end
   end

   assign in_ready        = rdy_q;
   assign next            = next_q;
   assign sample_active   = act_v_q;
   assign acc             = acc_q;
   assign child_direction = ~acc_q[ACC_WIDTH-1];
   assign overflow        = ovf_q;
   assign underrun        = und_q;

endmodule

// File: tb/tb_node_evaluator.sv
// tb_node_evaluator: directed test-plan scenarios plus randomized traffic against a queue-based model
module tb_node_evaluator;

`ifdef NODE_EVAL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam int AW_A = 15;
   localparam int AW_B = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0, in_valid = 1'b0, load_bias = 1'b0, add = 1'b0;
   logic        mult = 1'b0, is_one = 1'b0, tree_done = 1'b0;
   logic [23:0] in_features = '0;
   logic [3:0]  coeff = '0;
   logic [9:0]  bias = '0;

   logic        rdy_a, cd_a, nx_a, sa_a, ov_a, un_a;
   logic        rdy_b, cd_b, nx_b, sa_b, ov_b, un_b;
   logic [14:0] acc_a;
   logic [7:0]  acc_b;

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   node_evaluator dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a), .in_features(in_features),
      .load_bias(load_bias), .add(add), .mult(mult), .is_one(is_one), .coeff(coeff), .bias(bias),
      .tree_done(tree_done), .child_direction(cd_a), .next(nx_a), .sample_active(sa_a),
      .acc(acc_a), .overflow(ov_a), .underrun(un_a)
   );

   node_evaluator #(.ACC_WIDTH(AW_B)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .in_features(in_features),
      .load_bias(load_bias), .add(add), .mult(mult), .is_one(is_one), .coeff(coeff), .bias(bias),
      .tree_done(tree_done), .child_direction(cd_b), .next(nx_b), .sample_active(sa_b),
      .acc(acc_b), .overflow(ov_b), .underrun(un_b)
   );

   // ---------------- behavioural model ----------------
   logic [23:0] q[$];
   int m_acc[2] = '{0, 0};
   bit m_ovf[2] = '{0, 0};
   bit m_und = 0, m_next = 0, m_rdy = 0;
   int m_k = 0;

   function automatic int feat(input logic [23:0] v, input int i);
      logic [7:0] b;
      b = v[23 - 8*i -: 8];
      return int'($signed(b));
   endfunction

   function automatic int fit(input int s, input int aw, output bit ov);
      int mx, mn, m;
      mx = (1 << (aw - 1)) - 1;
      mn = -(1 << (aw - 1));
      m  = 1 << aw;
      ov = (s > mx) || (s < mn);
      if (!ov) return s;
      if (SAT) return s > mx ? mx : mn;
      return (((s - mn) % m) + m) % m + mn;
   endfunction

   always @(posedge clk) begin
      int i, x, t, s, bv, old;
      bit ov;
      if (!reset) begin
         q.delete();
         m_acc = '{0, 0};
         m_ovf = '{0, 0};
         m_und = 0; m_next = 0; m_rdy = 0; m_k = 0;
      end else begin
         if (add) begin
            i  = load_bias ? 0 : m_k;
            x  = q.size() > 0 ? feat(q[0], i) : 0;
            if (q.size() == 0) m_und = 1;
            t  = is_one ? x : mult ? x * int'($signed(coeff)) : 0;
            bv = int'($signed(bias));
            s  = (load_bias ? bv : m_acc[0]) + t;
            m_acc[0] = fit(s, AW_A, ov);
            if (ov) m_ovf[0] = 1;
            s  = (load_bias ? bv : m_acc[1]) + t;
            m_acc[1] = fit(s, AW_B, ov);
            if (ov) m_ovf[1] = 1;
            m_k = (i + 1) % 3;
         end
         old = q.size();
         if (tree_done && old > 0) void'(q.pop_front());
         m_next = tree_done && old == 2;
         if (in_valid && m_rdy) begin
            if (q.size() == 0) m_next = 1;
            q.push_back(in_features);
         end
         m_rdy = q.size() < 2;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Literal expectation pinning both the DUT and the model
   task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
      chk({name, "_dut"}, dut_v, exp);
      chk({name, "_model"}, mdl_v, exp);
   endtask

   task automatic compare();
      chk("in_ready_a", rdy_a, m_rdy);
      chk("next_a", nx_a, m_next);
      chk("active_a", sa_a, q.size() > 0);
      chk("acc_a", int'($signed(acc_a)), m_acc[0]);
      chk("child_a", cd_a, m_acc[0] >= 0);
      chk("overflow_a", ov_a, m_ovf[0]);
      chk("underrun_a", un_a, m_und);
      chk("in_ready_b", rdy_b, m_rdy);
      chk("next_b", nx_b, m_next);
      chk("acc_b", int'($signed(acc_b)), m_acc[1]);
      chk("child_b", cd_b, m_acc[1] >= 0);
      chk("overflow_b", ov_b, m_ovf[1]);
      chk("underrun_b", un_b, m_und);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic op(input bit lb, input bit ad, input bit ml, input bit one, input logic [3:0] c, input logic [9:0] b);
      load_bias = lb; add = ad; mult = ml; is_one = one; coeff = c; bias = b;
   endtask

   initial begin
      // reset values
      reset = 1'b0;
      tick();
      lit("rst_in_ready", rdy_a, m_rdy, 0);
      lit("rst_child", cd_a, m_acc[0] >= 0, 1);
      lit("rst_acc", int'($signed(acc_a)), m_acc[0], 0);
      reset = 1'b1;
      tick();
      lit("in_ready_after_release", rdy_a, m_rdy, 1);

      // add before any sample
      op(0, 1, 0, 0, 4'h0, 10'h0);
      tick();
      op(0, 0, 0, 0, 4'h0, 10'h0);
      lit("underrun", un_a, m_und, 1);
      reset = 1'b0; tick(); reset = 1'b1; tick();

      // features (10,-3,5)
      in_valid = 1'b1; in_features = {8'd10, 8'hFD, 8'd5};
      tick();
      in_valid = 1'b0;
      lit("next_first", nx_a, m_next, 1);
      lit("active_first", sa_a, q.size() > 0, 1);
      op(1, 1, 0, 1, 4'h0, 10'd4); tick();
      lit("acc_14", int'($signed(acc_a)), m_acc[0], 14);
      op(0, 1, 1, 0, 4'h2, 10'd0); tick();
      lit("acc_8", int'($signed(acc_a)), m_acc[0], 8);
      op(0, 1, 1, 0, 4'hF, 10'd0); tick();
      lit("acc_3", int'($signed(acc_a)), m_acc[0], 3);
      lit("child_pos", cd_a, m_acc[0] >= 0, 1);
      op(1, 1, 0, 1, 4'h0, 10'h3EC); tick();
      op(0, 1, 1, 0, 4'h2, 10'd0); tick();
      op(0, 1, 1, 0, 4'hF, 10'd0); tick();
      lit("acc_m21", int'($signed(acc_a)), m_acc[0], -21);
      lit("child_neg", cd_a, m_acc[0] >= 0, 0);
      op(0, 1, 0, 0, 4'h0, 10'd0); tick();
      lit("acc_hold", int'($signed(acc_a)), m_acc[0], -21);
      op(0, 0, 0, 0, 4'h0, 10'd0);

      // retire and accept together, then the 8-bit accumulator overflow case
      tree_done = 1'b1; in_valid = 1'b1; in_features = {8'd127, 8'd0, 8'd0};
      tick();
      tree_done = 1'b0; in_valid = 1'b0;
      lit("next_swap", nx_a, m_next, 1);
      op(1, 1, 0, 1, 4'h0, 10'd100); tick();
      op(0, 0, 0, 0, 4'h0, 10'd0);
      lit("acc8", int'($signed(acc_b)), m_acc[1], SAT ? 127 : -29);
      lit("ovf8", ov_b, m_ovf[1], 1);
      lit("acc15", int'($signed(acc_a)), m_acc[0], 227);

      // buffer flow
      reset = 1'b0; tick(); reset = 1'b1; tick();
      in_valid = 1'b1;
      in_features = {8'd1, 8'd2, 8'd3};  tick();
      in_features = {8'd20, 8'd2, 8'd3}; tick();
      in_features = {8'd30, 8'd2, 8'd3};
      lit("full_ready", rdy_a, m_rdy, 0);
      tick();
      tree_done = 1'b1; tick(); tree_done = 1'b0;
      lit("promote_next", nx_a, m_next, 1);
      lit("promote_ready", rdy_a, m_rdy, 1);
      tick();
      in_valid = 1'b0;
      lit("refull_ready", rdy_a, m_rdy, 0);
      op(1, 1, 0, 1, 4'h0, 10'd0); tick();
      lit("second_word", int'($signed(acc_a)), m_acc[0], 20);

      // reset mid-node
      op(0, 1, 1, 0, 4'h3, 10'd0);
      reset = 1'b0; tick();
      op(0, 0, 0, 0, 4'h0, 10'd0);
      lit("mid_acc", int'($signed(acc_a)), m_acc[0], 0);
      lit("mid_active", sa_a, q.size() > 0, 0);
      lit("mid_ready", rdy_a, m_rdy, 0);
      lit("mid_child", cd_a, m_acc[0] >= 0, 1);
      reset = 1'b1; tick();

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         reset       = ($urandom_range(0, 299) != 0);
         in_valid    = $urandom_range(0, 1);
         in_features = 24'($urandom);
         tree_done   = ($urandom_range(0, 5) == 0);
         add         = $urandom_range(0, 1);
         load_bias   = ($urandom_range(0, 3) == 0);
         mult        = $urandom_range(0, 1);
         is_one      = ($urandom_range(0, 3) == 0);
         coeff       = 4'($urandom);
         bias        = 10'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
